// File: rtl/adc_sample_capture_pio_if.sv
// Avalon-MM slave bus bundle used by adc_sample_capture_pio.
// The master modport is the Nios/bus side; the slave modport is the capture block.
interface adc_sample_capture_pio_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/adc_sample_capture_pio.sv
// ADC sample capture PIO: armed, optionally threshold-triggered, fixed-length
// capture into a FIFO read out over Avalon-MM, with sticky status and irq.
module adc_sample_capture_pio #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int LEVEL_W    = 13
) (
  input  logic                    clk,
  input  logic                    reset_n,
  adc_sample_capture_pio_if.slave bus,
  input  logic [DATA_WIDTH-1:0]   in_port,
  input  logic                    in_valid,
  output logic                    irq
);

  localparam int                 AW      = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] ONE_L   = LEVEL_W'(1);
  localparam logic [AW-1:0]      ONE_P   = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LEVEL_W-1:0]    level;

  logic [LEVEL_W-1:0]    cap_count;
  logic [LEVEL_W-1:0]    cap_count_next;
  logic [LEVEL_W-1:0]    length;
  logic [LEVEL_W-1:0]    eff_length;
  logic [DATA_WIDTH-1:0] threshold;
  logic [DATA_WIDTH-1:0] prev_sample;
  logic [DATA_WIDTH-1:0] live;
  logic                  irq_en;
  logic                  trig_mode;
  logic                  overflow;
  logic                  done;

  logic                  wr_en;
  logic                  rd_en;
  logic                  ctrl_wr;
  logic                  arm_cmd;
  logic                  abort_cmd;
  logic                  flush_cmd;
  logic                  clear_wr;
  logic                  pop_cmd;
  logic                  empty;
  logic                  full;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  overflow_set;
  logic                  trig_hit;

  logic                  cap_push;
  logic                  set_done;
  logic                  arm_start;
  logic                  cnt_inc;
  logic                  prev_load;

  logic [31:0]           status;
  logic [31:0]           read_mux;
  logic                  unused_writedata;

  assign wr_en     = bus.chipselect & bus.write;
  assign rd_en     = bus.chipselect & bus.read;
  assign ctrl_wr   = wr_en & (bus.address == 3'd2);
  assign arm_cmd   = ctrl_wr & bus.writedata[0];
  assign abort_cmd = ctrl_wr & bus.writedata[1];
  assign flush_cmd = ctrl_wr & bus.writedata[2];
  assign clear_wr  = wr_en & (bus.address == 3'd5);
  assign pop_cmd   = rd_en & (bus.address == 3'd0);

  assign unused_writedata = ^bus.writedata;

  assign empty          = (level == '0);
  assign full           = (level == DEPTH_L);
  assign eff_length     = ((length == '0) || (length > DEPTH_L)) ? DEPTH_L : length;
  assign cap_count_next = cap_count + ONE_L;
  assign trig_hit       = (in_port >= threshold) && (prev_sample < threshold);

  // Flush wins over everything; a full FIFO still accepts a push when a pop frees a slot.
  assign pop_ok       = pop_cmd & ~empty & ~flush_cmd;
  assign push_ok      = cap_push & ~flush_cmd & (~full | pop_ok);
  assign overflow_set = cap_push & ~flush_cmd & full & ~pop_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cap_push   = 1'b0;
    set_done   = 1'b0;
    arm_start  = 1'b0;
    cnt_inc    = 1'b0;
    prev_load  = 1'b0;
    case (state)
      IDLE: begin
        if (arm_cmd) begin
          arm_start  = 1'b1;
          next_state = bus.writedata[4] ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (abort_cmd) begin
          next_state = IDLE;
        end else if (in_valid) begin
          prev_load = 1'b1;
          if (trig_hit) begin
            cap_push = 1'b1;
            cnt_inc  = 1'b1;
            if (cap_count_next == eff_length) begin
              set_done   = 1'b1;
              next_state = IDLE;
            end else begin
              next_state = CAPTURE;
            end
          end
        end
      end
      CAPTURE: begin
        if (abort_cmd) begin
          next_state = IDLE;
        end else if (in_valid) begin
          cap_push = 1'b1;
          cnt_inc  = 1'b1;
          if (cap_count_next == eff_length) begin
            set_done   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en      <= 1'b0;
      trig_mode   <= 1'b0;
      threshold   <= '0;
      length      <= '0;
      cap_count   <= '0;
      prev_sample <= '1;
      overflow    <= 1'b0;
      done        <= 1'b0;
      live        <= '0;
    end else begin
      live <= in_port;
      if (ctrl_wr) begin
        irq_en    <= bus.writedata[3];
        trig_mode <= bus.writedata[4];
      end
      if (wr_en && (bus.address == 3'd3)) begin
        threshold <= bus.writedata[DATA_WIDTH-1:0];
      end
      if (wr_en && (bus.address == 3'd4)) begin
        length <= bus.writedata[LEVEL_W-1:0];
      end
      // All-ones history means the first sample after arming can never look like a crossing.
      if (arm_start) begin
        cap_count   <= '0;
        prev_sample <= '1;
      end else begin
        if (cnt_inc) begin
          cap_count <= cap_count_next;
        end
        if (prev_load) begin
          prev_sample <= in_port;
        end
      end
      if (arm_start) begin
        done <= 1'b0;
      end else if (set_done) begin
        done <= 1'b1;
      end else if (clear_wr && bus.writedata[19]) begin
        done <= 1'b0;
      end
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clear_wr && bus.writedata[18]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_cmd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      if (push_ok && !pop_ok) begin
        level <= level + ONE_L;
      end else if (pop_ok && !push_ok) begin
        level <= level - ONE_L;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= in_port;
    end
  end

  always_comb begin
    status                = '0;
    status[LEVEL_W-1:0]   = level;
    status[16]            = empty;
    status[17]            = full;
    status[18]            = overflow;
    status[19]            = done;
    status[21:20]         = 2'(state);
  end

  always_comb begin
    read_mux = '0;
    case (bus.address)
      3'd0:    read_mux = pop_ok ? 32'(mem[rd_ptr]) : 32'd0;
      3'd1:    read_mux = status;
      3'd2:    read_mux = {27'd0, trig_mode, irq_en, 3'd0};
      3'd3:    read_mux = 32'(threshold);
      3'd4:    read_mux = 32'(length);
      3'd6:    read_mux = 32'(live);
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (rd_en) begin
        bus.readdata <= read_mux;
      end
      irq <= irq_en & (done | overflow);
    end
  end

endmodule

// File: tb/tb_adc_sample_capture_pio.sv
// Self-checking bench for adc_sample_capture_pio: directed scenarios followed by
// randomized bus/sample traffic, all compared against a queue-based reference model.
module tb_adc_sample_capture_pio;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int LW    = 13;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_port;
  logic          in_valid;
  logic          irq;

  adc_sample_capture_pio_if bus ();

  adc_sample_capture_pio #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEVEL_W   (LW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .in_valid(in_valid),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state: FIFO as a queue, capture mode as the status-field value.
  int unsigned q[$];
  int unsigned m_mode;
  int unsigned m_thr, m_len, m_cnt, m_prev, m_live;
  bit          m_ovf, m_done, m_irq_en, m_trig, m_irq;
  logic [31:0] m_rd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_mode = 0; m_thr = 0; m_len = 0; m_cnt = 0; m_prev = 0; m_live = 0;
    m_ovf = 0; m_done = 0; m_irq_en = 0; m_trig = 0; m_irq = 0;
    m_rd = '0;
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = 32'(q.size());
    if (q.size() == 0)     s |= 32'h0001_0000;
    if (q.size() == DEPTH) s |= 32'h0002_0000;
    if (m_ovf)             s |= 32'h0004_0000;
    if (m_done)            s |= 32'h0008_0000;
    s |= 32'(m_mode) << 20;
    return s;
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit          w, r, arm, abort, flush, push_req, pop_now;
    int unsigned a, s, eff_len;
    logic [31:0] d, new_rd;
    bit          new_irq;
    w = bus.chipselect && bus.write;
    r = bus.chipselect && bus.read;
    a = bus.address;
    d = bus.writedata;
    s = in_port;
    arm   = w && a == 2 && d[0];
    abort = w && a == 2 && d[1];
    flush = w && a == 2 && d[2];
    eff_len = (m_len == 0 || m_len > DEPTH) ? DEPTH : m_len;
    pop_now = r && a == 0 && q.size() > 0 && !flush;
    new_rd = m_rd;
    if (r) begin
      case (a)
        0:       new_rd = pop_now ? 32'(q[0]) : 32'd0;
        1:       new_rd = modelStatus();
        2:       new_rd = (m_trig ? 32'h10 : 32'h0) | (m_irq_en ? 32'h8 : 32'h0);
        3:       new_rd = m_thr;
        4:       new_rd = m_len;
        6:       new_rd = m_live;
        default: new_rd = 32'd0;
      endcase
    end
    new_irq = m_irq_en && (m_done || m_ovf);
    if (w && a == 5) begin
      if (d[18]) m_ovf = 0;
      if (d[19]) m_done = 0;
    end
    push_req = 0;
    case (m_mode)
      0: if (arm) begin
        m_done = 0;
        m_cnt  = 0;
        m_prev = (1 << DW) - 1;
        m_mode = d[4] ? 1 : 2;
      end
      1: if (abort) m_mode = 0;
         else if (in_valid) begin
           if (s >= m_thr && m_prev < m_thr) begin
             push_req = 1;
             m_cnt++;
             m_mode = 2;
             if (m_cnt == eff_len) begin m_done = 1; m_mode = 0; end
           end
           m_prev = s;
         end
      default: if (abort) m_mode = 0;
         else if (in_valid) begin
           push_req = 1;
           m_cnt++;
           if (m_cnt == eff_len) begin m_done = 1; m_mode = 0; end
         end
    endcase
    if (flush) begin
      q.delete();
    end else begin
      if (pop_now) void'(q.pop_front());
      if (push_req) begin
        if (q.size() < DEPTH) q.push_back(s);
        else m_ovf = 1;
      end
    end
    if (w && a == 2) begin m_irq_en = d[3]; m_trig = d[4]; end
    if (w && a == 3) m_thr = d[DW-1:0];
    if (w && a == 4) m_len = d[LW-1:0];
    m_live = s;
    m_rd   = new_rd;
    m_irq  = new_irq;
  endtask

  task automatic applyStimulus(input bit cs, input bit rd, input bit wr, input logic [2:0] a,
                               input logic [31:0] d, input bit v, input logic [DW-1:0] s);
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    in_valid       = v;
    in_port        = s;
    modelStep();
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    in_valid       = 1'b0;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d, 1'b0, in_port);
  endtask

  task automatic pushSample(input logic [DW-1:0] s);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, s);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, in_port);
  endtask

  task automatic readCheck(input string tag, input logic [2:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, in_port);
    checkOutput(tag, bus.readdata, m_rd);
  endtask

  task automatic readExpect(input string tag, input logic [2:0] a, input logic [31:0] exp);
    readCheck(tag, a);
    checkOutput({tag, " const"}, bus.readdata, exp);
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    in_port        = '0;
    in_valid       = 1'b0;
    reset_n        = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state across the whole map.
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      readExpect($sformatf("reset addr%0d", a), 3'(a), (a == 1) ? 32'h0001_0000 : 32'd0);
    end

    // Immediate capture of four samples.
    busWrite(3'd4, 32'd4);
    busWrite(3'd2, 32'h01);
    for (int i = 0; i < 6; i++) pushSample(DW'(16'h0011 + i));
    readExpect("imm status", 3'd1, 32'h0008_0004);
    for (int i = 0; i < 4; i++) readExpect($sformatf("imm data%0d", i), 3'd0, 32'h11 + i);
    readExpect("imm empty read", 3'd0, 32'd0);

    // Threshold-triggered capture; first sample must not trigger.
    busWrite(3'd3, 32'h0100);
    busWrite(3'd4, 32'd3);
    busWrite(3'd2, 32'h11);
    pushSample(16'h0200);
    pushSample(16'h0050);
    pushSample(16'h0120);
    pushSample(16'h0130);
    pushSample(16'h0140);
    readExpect("trig status", 3'd1, 32'h0008_0003);
    readExpect("trig data0", 3'd0, 32'h120);
    readExpect("trig data1", 3'd0, 32'h130);
    readExpect("trig data2", 3'd0, 32'h140);
    readExpect("trig empty", 3'd0, 32'd0);

    // Overflow: preload 60, then a full-depth capture of 64.
    busWrite(3'd4, 32'd60);
    busWrite(3'd2, 32'h01);
    for (int i = 0; i < 60; i++) pushSample(DW'(16'h1000 + i));
    readExpect("preload status", 3'd1, 32'h0008_003C);
    busWrite(3'd4, 32'd0);
    busWrite(3'd2, 32'h01);
    for (int i = 0; i < 64; i++) pushSample(DW'(16'h2000 + i));
    readExpect("ovf status", 3'd1, 32'h000E_0040);
    busWrite(3'd2, 32'h08);
    idleCycle();
    checkOutput("irq set", {31'd0, irq}, {31'd0, m_irq});
    checkOutput("irq set const", {31'd0, irq}, 32'd1);
    busWrite(3'd5, 32'h000C_0000);
    idleCycle();
    checkOutput("irq clear", {31'd0, irq}, 32'd0);

    // Full FIFO: pop and push together, then flush with a push.
    busWrite(3'd4, 32'd3);
    busWrite(3'd2, 32'h09);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 16'hABCD);
    checkOutput("full poppush", bus.readdata, m_rd);
    checkOutput("full poppush const", bus.readdata, 32'h1000);
    readExpect("full level", 3'd1, 32'h0022_0040);
    readExpect("head advanced", 3'd0, 32'h1001);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 32'h0C, 1'b1, 16'h1234);
    readExpect("flush status", 3'd1, 32'h0021_0000);
    busWrite(3'd2, 32'h02);

    // Abort while armed, then reset in the middle of a capture.
    busWrite(3'd2, 32'h11);
    readExpect("armed status", 3'd1, 32'h0011_0000);
    busWrite(3'd2, 32'h02);
    readExpect("abort status", 3'd1, 32'h0001_0000);
    busWrite(3'd4, 32'd10);
    busWrite(3'd2, 32'h09);
    for (int i = 0; i < 3; i++) pushSample(DW'(16'h3000 + i));
    reset_n = 1'b0;
    #1;
    checkOutput("async reset readdata", bus.readdata, 32'd0);
    checkOutput("async reset irq", {31'd0, irq}, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    readExpect("post reset status", 3'd1, 32'h0001_0000);
    readExpect("post reset length", 3'd4, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned   r;
      bit            v;
      logic [DW-1:0] s;
      logic [31:0]   d;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 2) != 0);
      s = DW'($urandom);
      if (r < 30) begin
        applyStimulus(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'd0, v, s);
        checkOutput("rand read", bus.readdata, m_rd);
      end else if (r < 34) begin
        d = 32'd0;
        d[0] = ($urandom_range(0, 1) == 1);
        d[1] = ($urandom_range(0, 9) == 0);
        d[2] = ($urandom_range(0, 9) == 0);
        d[3] = ($urandom_range(0, 1) == 1);
        d[4] = ($urandom_range(0, 1) == 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, d, v, s);
      end else if (r < 36) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, $urandom, v, s);
      end else if (r < 38) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, $urandom_range(0, 80), v, s);
      end else if (r < 39) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, $urandom & 32'h000C_0000, v, s);
      end else if (r < 41) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, v, s);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, v, s);
      end
      if ((n % 4) == 0) checkOutput("rand irq", {31'd0, irq}, {31'd0, m_irq});
    end
    readCheck("final status", 3'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
